// File: rtl/tlk2711_dma_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_dma_wr_pkg
// Description : Shared AXI constants, 4 KB boundary and FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tlk2711_dma_wr_pkg;

    localparam logic [1:0] c_axi_burst_incr  = 2'b01;
    localparam logic [2:0] c_axi_size_8b     = 3'd3;
    localparam logic [1:0] c_axi_resp_okay   = 2'b00;
    localparam logic [1:0] c_axi_resp_slverr = 2'b10;

    localparam int c_boundary_4k   = 4096;
    localparam int c_boundary_bits = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tlk2711_burst_calc.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_burst_calc
// Description : Burst length = min(remaining beats, MAX_BURST, beats to 4 KB).
// Revision    : 1.0 - initial release
// ============================================================================
module tlk2711_burst_calc
    import tlk2711_dma_wr_pkg::*;
#(
    parameter int REM_WIDTH   = 14,
    parameter int MAX_BURST   = 16,
    parameter int WBYTE_WIDTH = 8,
    parameter int BEAT_SHIFT  = $clog2(WBYTE_WIDTH),
    parameter int BL_WIDTH    = $clog2(MAX_BURST + 1)
) (
    input  logic [c_boundary_bits-1:BEAT_SHIFT] i_addr_beat,
    input  logic [REM_WIDTH-1:0]                i_remain,
    output logic [BL_WIDTH-1:0]                 o_burst_len
);

    localparam int BND_BEATS = c_boundary_4k / WBYTE_WIDTH;

    logic [31:0] w_remain;
    logic [31:0] w_to_bnd;
    logic [31:0] w_min_a;
    logic [31:0] w_min;

    always_comb begin
        w_remain    = 32'(i_remain);
        w_to_bnd    = 32'(BND_BEATS) - 32'(i_addr_beat);
        w_min_a     = (w_remain < 32'(MAX_BURST)) ? w_remain : 32'(MAX_BURST);
        w_min       = (w_to_bnd < w_min_a) ? w_to_bnd : w_min_a;
        o_burst_len = BL_WIDTH'(w_min);
    end

endmodule
`default_nettype wire

// File: rtl/tlk2711_dma_wr.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_dma_wr
// Description : Stream-to-AXI4 write DMA, 4 KB-safe bursts, abortable.
// Revision    : 1.0 - initial release
// ============================================================================
module tlk2711_dma_wr
    import tlk2711_dma_wr_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DLEN_WIDTH  = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int WBYTE_WIDTH = 8,
    parameter int MAX_BURST   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_soft_rst,

    input  logic                             i_wr_cmd_req,
    output logic                             o_wr_cmd_ack,
    input  logic [ADDR_WIDTH+DLEN_WIDTH-1:0] i_wr_cmd_data,

    output logic                             o_dma_wr_ready,
    input  logic                             i_dma_wr_valid,
    input  logic [DATA_WIDTH-1:0]            i_dma_wr_data,
    input  logic [WBYTE_WIDTH-1:0]           i_dma_wr_keep,

    output logic                             o_wr_finish,
    output logic                             o_wr_err,
    output logic [3:0]                       o_wr_status,

    output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic [7:0]                       m_axi_awlen,
    output logic [2:0]                       m_axi_awsize,
    output logic [1:0]                       m_axi_awburst,
    output logic                             m_axi_awvalid,
    input  logic                             m_axi_awready,
    output logic [DATA_WIDTH-1:0]            m_axi_wdata,
    output logic [WBYTE_WIDTH-1:0]           m_axi_wstrb,
    output logic                             m_axi_wlast,
    output logic                             m_axi_wvalid,
    input  logic                             m_axi_wready,
    input  logic [1:0]                       m_axi_bresp,
    input  logic                             m_axi_bvalid,
    output logic                             m_axi_bready
);

    localparam int BEAT_SHIFT = $clog2(WBYTE_WIDTH);
    localparam int REM_WIDTH  = DLEN_WIDTH - BEAT_SHIFT + 1;
    localparam int BL_WIDTH   = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_WIDTH-1:0] c_beat_mask = ADDR_WIDTH'(WBYTE_WIDTH - 1);

    // Async-assert / sync-deassert reset for everything below
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_int_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    state_t                 state_q,    state_d;
    logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
    logic [REM_WIDTH-1:0]   remain_q,   remain_d;
    logic [7:0]             beat_cnt_q, beat_cnt_d;
    logic [7:0]             awlen_q,    awlen_d;
    logic                   awvalid_q,  awvalid_d;
    logic                   finish_q,   finish_d;
    logic                   err_q,      err_d;
    logic                   abort_q,    abort_d;

    logic [ADDR_WIDTH-1:0]  w_cmd_addr;
    logic [DLEN_WIDTH-1:0]  w_cmd_len;
    logic [REM_WIDTH-1:0]   w_cmd_beats;
    logic [BL_WIDTH-1:0]    w_burst_len;
    logic [7:0]             w_awlen;
    logic                   w_accept;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_wlast;

    assign w_cmd_addr  = i_wr_cmd_data[ADDR_WIDTH+DLEN_WIDTH-1:DLEN_WIDTH];
    assign w_cmd_len   = i_wr_cmd_data[DLEN_WIDTH-1:0];
    assign w_cmd_beats = REM_WIDTH'(w_cmd_len[DLEN_WIDTH-1:BEAT_SHIFT])
                       + REM_WIDTH'(|w_cmd_len[BEAT_SHIFT-1:0]);

    tlk2711_burst_calc #(
        .REM_WIDTH   (REM_WIDTH),
        .MAX_BURST   (MAX_BURST),
        .WBYTE_WIDTH (WBYTE_WIDTH),
        .BEAT_SHIFT  (BEAT_SHIFT),
        .BL_WIDTH    (BL_WIDTH)
    ) u_burst_calc (
        .i_addr_beat (addr_q[c_boundary_bits-1:BEAT_SHIFT]),
        .i_remain    (remain_q),
        .o_burst_len (w_burst_len)
    );

    // Gated by the internal reset so no ack can leak out while held in reset
    assign w_accept = rst_int_n & (state_q == ST_IDLE) & i_wr_cmd_req & ~i_soft_rst;
    assign w_awlen  = 8'(w_burst_len) - 8'd1;
    assign w_aw_hs  = awvalid_q & m_axi_awready;
    assign w_w_hs   = m_axi_wvalid & m_axi_wready;
    assign w_wlast  = (state_q == ST_DATA) & (beat_cnt_q == awlen_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        beat_cnt_d = beat_cnt_q;
        awlen_d    = awlen_q;
        awvalid_d  = awvalid_q;
        finish_d   = 1'b0;
        err_d      = err_q;
        abort_d    = abort_q;

        if (i_soft_rst && (state_q != ST_IDLE)) abort_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (i_soft_rst) begin
                    addr_d     = '0;
                    remain_d   = '0;
                    beat_cnt_d = '0;
                    awlen_d    = '0;
                    err_d      = 1'b0;
                    abort_d    = 1'b0;
                end else if (w_accept) begin
                    addr_d   = w_cmd_addr & ~c_beat_mask;
                    remain_d = w_cmd_beats;
                    err_d    = 1'b0;
                    if (w_cmd_beats == '0) begin
                        finish_d = 1'b1;
                    end else begin
                        state_d   = ST_ADDR;
                        awvalid_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                // Address and remaining count advance as soon as AW is taken
                if (w_aw_hs) begin
                    awvalid_d  = 1'b0;
                    awlen_d    = w_awlen;
                    beat_cnt_d = '0;
                    addr_d     = addr_q + (ADDR_WIDTH'(w_burst_len) << BEAT_SHIFT);
                    remain_d   = remain_q - REM_WIDTH'(w_burst_len);
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_w_hs) begin
                    if (w_wlast) begin
                        beat_cnt_d = '0;
                        state_d    = ST_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != c_axi_resp_okay) err_d = 1'b1;
                    if (abort_q || i_soft_rst) begin
                        state_d  = ST_IDLE;
                        remain_d = '0;
                        abort_d  = 1'b0;
                    end else if (remain_q != '0) begin
                        state_d   = ST_ADDR;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        finish_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            beat_cnt_q <= '0;
            awlen_q    <= '0;
            awvalid_q  <= 1'b0;
            finish_q   <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            beat_cnt_q <= beat_cnt_d;
            awlen_q    <= awlen_d;
            awvalid_q  <= awvalid_d;
            finish_q   <= finish_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
        end
    end

    assign o_wr_cmd_ack   = w_accept;
    assign o_wr_finish    = finish_q;
    assign o_wr_err       = err_q;
    assign o_wr_status    = {(state_q != ST_IDLE), err_q, state_q};

    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = w_awlen;
    assign m_axi_awsize   = c_axi_size_8b;
    assign m_axi_awburst  = c_axi_burst_incr;
    assign m_axi_awvalid  = awvalid_q;

    // Ready must not look at valid: upstream valid is gated by this ready
    assign o_dma_wr_ready = (state_q == ST_DATA) & m_axi_wready;
    assign m_axi_wvalid   = i_dma_wr_valid & (state_q == ST_DATA);
    assign m_axi_wdata    = i_dma_wr_data;
    assign m_axi_wstrb    = i_dma_wr_keep;
    assign m_axi_wlast    = w_wlast;
    assign m_axi_bready   = (state_q == ST_RESP);

endmodule
`default_nettype wire

// File: doc/tlk2711_dma_wr.md
TLK2711_DMA_WR -- requirements
Module: tlk2711_dma_wr

Interface
REQ-001 Parameters: ADDR_WIDTH 32 (byte address width); DLEN_WIDTH 16 (byte-length width); DATA_WIDTH 64 (data beat width); WBYTE_WIDTH 8 (bytes per beat); MAX_BURST 16 (max AXI beats per burst).
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 Clock and reset ports SHALL be:
- clk, in, 1: sole clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_soft_rst, in, 1: synchronous soft reset, active-high.
REQ-004 Command ports SHALL be:
- i_wr_cmd_req, in, 1: command request.
- o_wr_cmd_ack, out, 1: one-cycle command accept.
- i_wr_cmd_data, in, ADDR_WIDTH+DLEN_WIDTH: {start byte addr, byte length}.
REQ-005 Stream ports SHALL be:
- o_dma_wr_ready, out, 1: sink ready.
- i_dma_wr_valid, in, 1: beat valid.
- i_dma_wr_data, in, DATA_WIDTH: beat data.
- i_dma_wr_keep, in, WBYTE_WIDTH: byte enables.
REQ-006 Completion and status ports SHALL be:
- o_wr_finish, out, 1: one-cycle pulse when a command completes.
- o_wr_err, out, 1: sticky BRESP error flag.
- o_wr_status, out, 4: {busy, err, state[1:0]}.
REQ-007 AXI4 write master ports SHALL be:
- m_axi_awaddr / awlen / awsize / awburst / awvalid / awready.
- m_axi_wdata / wstrb / wlast / wvalid / wready.
- m_axi_bresp / bvalid / bready.

Function
REQ-008 States SHALL be IDLE, ADDR, DATA, RESP.
- IDLE->ADDR on accepted command with nonzero length.
- ADDR->DATA on awvalid&awready.
- DATA->RESP on the wlast handshake.
- RESP->ADDR on bvalid if beats remain, else RESP->IDLE.
REQ-009 o_wr_cmd_ack SHALL pulse for one cycle when i_wr_cmd_req=1 in IDLE; address and length SHALL be latched in that cycle.
REQ-010 Beat count SHALL be ceil(len/8), i.e. len[15:3] + |len[2:0]; remaining-beat counter width SHALL be DLEN_WIDTH-3+1.
REQ-011 A command with length 0 SHALL produce no AXI traffic; o_wr_finish SHALL pulse on the cycle after the ack.
REQ-012 Burst length SHALL be min(remaining beats, MAX_BURST, beats to next 4 KB boundary); awlen SHALL equal burst length minus 1.
REQ-013 AXI field values SHALL be fixed: awsize=3, awburst=INCR.
REQ-014 Start address SHALL be treated as 8-byte aligned (bits [2:0] forced to 0); after each burst the address SHALL advance by burst_len*8.
REQ-015 awvalid SHALL be registered, high throughout ADDR, and held until awready.
REQ-016 o_dma_wr_ready SHALL equal (state==DATA) & m_axi_wready; it SHALL NOT depend on i_dma_wr_valid, because the upstream valid is combinationally gated by this ready.
REQ-017 The data path SHALL be combinational pass-through with zero latency:
- wvalid = i_dma_wr_valid & (state==DATA).
- wdata = i_dma_wr_data; wstrb = i_dma_wr_keep.
REQ-018 wlast SHALL assert on the beat where the in-burst beat counter equals awlen.
REQ-019 bready SHALL be 1 in RESP only.
REQ-020 bresp!=OKAY SHALL set o_wr_err; transfer SHALL continue.
REQ-021 o_wr_err SHALL clear only on reset, soft reset, or the next command accept.
REQ-022 o_wr_finish SHALL pulse one cycle after the final bvalid handshake (registered).
REQ-023 i_soft_rst asserted in IDLE SHALL take effect immediately.
REQ-024 i_soft_rst asserted in ADDR/DATA/RESP SHALL be latched as a pending abort:
- The current burst completes, including its B response.
- The block then returns to IDLE, drops remaining beats, and does not pulse o_wr_finish.
REQ-025 A new command SHALL be accepted only in IDLE; i_wr_cmd_req while busy SHALL be ignored (held by the requester).

Reset
REQ-026 Under reset (rst_n=0) the following SHALL hold:
- state=IDLE.
- All counters, the address register, the pending-abort flag and o_wr_err cleared.
- o_wr_cmd_ack, awvalid, bready, o_wr_finish and o_dma_wr_ready = 0.
REQ-027 Reset SHALL assert asynchronously and deassert synchronously via a two-flop rst_n synchronizer inside the block.

Structure
REQ-028 The shared package SHALL hold AXI burst/size/resp constants, the 4 KB boundary constant and the state encoding.
REQ-029 Burst-length computation SHALL be a sub-module, tlk2711_burst_calc (combinational min-of-three), instantiated once.

Verification
REQ-030 addr 0x1000_0000, len 882 -> 111 beats as bursts 16×6 + 15; final wlast on beat 111; one o_wr_finish.
REQ-031 addr 0x0000_0FC0, len 256 (32 beats) -> bursts of 8 beats at 0x0FC0, then 16 at 0x1000, then 8 at 0x1080; no burst crosses 4 KB.
REQ-032 len 0 -> ack, no awvalid, o_wr_finish one cycle later.
REQ-033 wready toggling 1/0 and i_dma_wr_valid gaps, len 128 -> exactly 16 beats transferred in order; ready never asserted outside DATA.
REQ-034 bresp=SLVERR on burst 2 of 3 -> o_wr_err=1, all 3 bursts issued, o_wr_finish pulses.
REQ-035 Two abort cases:
- i_soft_rst mid-DATA of burst 1 of 3 -> burst 1 completes with its B, then IDLE, no o_wr_finish.
- rst_n low mid-burst -> all outputs at reset values immediately.
